// File: rtl/wb_stage_pkg.sv
// Shared write-back stage constants: load-op encoding and GR address width.
package wb_stage_pkg;

  localparam int unsigned LD_OP_W   = 3;
  localparam int unsigned GR_ADDR_W = 5;

  // Encodings 6 and 7 are unused and treated as LD_NONE.
  typedef enum logic [LD_OP_W-1:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5
  } ld_op_e;

  typedef struct packed {
    logic [31:0]          pc;
    logic                 gr_we;
    logic [GR_ADDR_W-1:0] dest;
    logic [31:0]          result;
    logic [LD_OP_W-1:0]   ld_op;
    logic [1:0]           addr_lo;
    logic [31:0]          ld_data;
  } ws_bus_t;

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed byte/half of the read word and extends it.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [31:0]        ld_data_i,
  output logic               is_load_o,
  output logic [31:0]        aligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = ld_data_i[{addr_lo_i, 3'b000} +: 8];
    // addr_lo[0] is ignored for halfwords; misaligned accesses trap upstream.
    half_v    = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    is_load_o = 1'b1;
    aligned_o = '0;
    case (ld_op_i)
      LD_B:    aligned_o = {{24{byte_v[7]}}, byte_v};
      LD_BU:   aligned_o = {24'h0, byte_v};
      LD_H:    aligned_o = {{16{half_v[15]}}, half_v};
      LD_HU:   aligned_o = {16'h0, half_v};
      LD_W:    aligned_o = ld_data_i;
      default: is_load_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM->WB pipeline register, regfile write port, ID bypass,
// debug trace and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic                 ms_gr_we,
  input  logic [GR_ADDR_W-1:0] ms_dest,
  input  logic [31:0]          ms_result,
  input  logic [LD_OP_W-1:0]   ms_ld_op,
  input  logic [1:0]           ms_ld_addr_lo,
  input  logic [31:0]          ms_ld_data,
  input  logic                 trace_stall,
  output logic                 rf_we,
  output logic [GR_ADDR_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 ws_fwd_valid,
  output logic [GR_ADDR_W-1:0] ws_fwd_dest,
  output logic [31:0]          ws_fwd_data,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [GR_ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata,
  output logic [RETIRE_W-1:0]  retire_cnt
);

  logic                ws_valid_q, ws_valid_d;
  ws_bus_t             bus_q, bus_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                ws_ready_go;
  logic                is_load;
  logic [31:0]         aligned;
  logic [31:0]         final_data;

  load_align u_load_align (
    .ld_op_i   (bus_q.ld_op),
    .addr_lo_i (bus_q.addr_lo),
    .ld_data_i (bus_q.ld_data),
    .is_load_o (is_load),
    .aligned_o (aligned)
  );

  always_comb begin
    ws_ready_go = ~trace_stall;
    ws_allowin  = ~ws_valid_q | ws_ready_go;
    // While allowin is high the register either takes the new instruction or empties.
    ws_valid_d  = ws_allowin ? ms_to_ws_valid : ws_valid_q;
    bus_d       = bus_q;
    if (ms_to_ws_valid && ws_allowin) begin
      bus_d.pc      = ms_pc;
      bus_d.gr_we   = ms_gr_we;
      bus_d.dest    = ms_dest;
      bus_d.result  = ms_result;
      bus_d.ld_op   = ms_ld_op;
      bus_d.addr_lo = ms_ld_addr_lo;
      bus_d.ld_data = ms_ld_data;
    end
    retire_d = retire_q;
    if (ws_valid_q && ws_ready_go) begin
      retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
      retire_q   <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
      retire_q   <= retire_d;
    end
  end

  always_comb begin
    final_data        = is_load ? aligned : bus_q.result;
    rf_we             = ws_valid_q & bus_q.gr_we & ws_ready_go;
    rf_waddr          = bus_q.dest;
    rf_wdata          = final_data;
    // Held through stalls so ID keeps bypassing the pending value.
    ws_fwd_valid      = ws_valid_q & bus_q.gr_we & (bus_q.dest != '0);
    ws_fwd_dest       = bus_q.dest;
    ws_fwd_data       = final_data;
    debug_wb_pc       = bus_q.pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = bus_q.dest;
    debug_wb_rf_wdata = final_data;
    retire_cnt        = retire_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomised scoreboard bench for wb_stage plus directed reset/stall/wrap cases.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic [2:0]  ms_ld_op;
  logic [1:0]  ms_ld_addr_lo;
  logic [31:0] ms_ld_data;
  logic        trace_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  wb_stage #(.RETIRE_W(32)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_result         (ms_result),
    .ms_ld_op          (ms_ld_op),
    .ms_ld_addr_lo     (ms_ld_addr_lo),
    .ms_ld_data        (ms_ld_data),
    .trace_stall       (trace_stall),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_dest       (ws_fwd_dest),
    .ws_fwd_data       (ws_fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_cnt        (retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mv;          // model: WB holds an instruction
  logic [31:0] exp_retire;  // model retire count

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Load result from the architectural rules: shift the word, mask, extend.
  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] d, input logic [31:0] res);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * lo)) & 32'hFF;
    h = lo[1] ? (d >> 16) : (d & 32'hFFFF);
    case (op)
      3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      3'd5:    return d;
      default: return res;
    endcase
  endfunction

  // Drives one cycle of MEM-stage inputs at the falling edge and updates the model.
  task automatic issue(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] dest, input logic [31:0] res, input logic [2:0] op,
                       input logic [1:0] lo, input logic [31:0] data, input logic stall);
    logic allow;
    @(negedge clk);
    ms_to_ws_valid = v;
    ms_pc          = pc;
    ms_gr_we       = we;
    ms_dest        = dest;
    ms_result      = res;
    ms_ld_op       = op;
    ms_ld_addr_lo  = lo;
    ms_ld_data     = data;
    trace_stall    = stall;
    #1;
    allow = !mv || !stall;
    check("allowin", {31'b0, ws_allowin}, {31'b0, allow});
    check("retire_cnt", retire_cnt, exp_retire);
    if (mv && !stall) exp_retire = exp_retire + 32'd1;
    if (v && allow && we) exp_q.push_back('{pc: pc, dest: dest, data: ref_data(op, lo, data, res)});
    if (allow) mv = v;
  endtask

  task automatic idle(input logic stall);
    issue(1'b0, $urandom, 1'b1, 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom,
          stall);
  endtask

  task automatic issue_simple(input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] res);
    issue(1'b1, pc, 1'b1, dest, res, 3'd0, 2'd0, 32'h0, 1'b0);
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (resetn === 1'b1 && rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rf_we", {31'b0, rf_we}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.dest});
          check("rf_wdata", rf_wdata, e.data);
          check("debug_wb_pc", debug_wb_pc, e.pc);
          check("debug_wb_rf_we", {28'b0, debug_wb_rf_we}, 32'hF);
          check("debug_wb_rf_wnum", {27'b0, debug_wb_rf_wnum}, {27'b0, e.dest});
          check("debug_wb_rf_wdata", debug_wb_rf_wdata, e.data);
          check("ws_fwd_data", ws_fwd_data, e.data);
          check("ws_fwd_valid", {31'b0, ws_fwd_valid}, {31'b0, e.dest != 5'd0});
        end
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] data;
    logic [31:0] req;
  } ld_vec_t;

  initial begin
    ld_vec_t     vecs[6];
    logic [31:0] rc;
    int          pulses;

    vecs[0] = '{op: 3'd1, lo: 2'd3, data: 32'h80FF7F01, req: 32'hFFFFFF80};
    vecs[1] = '{op: 3'd2, lo: 2'd1, data: 32'h80FF7F01, req: 32'h0000007F};
    vecs[2] = '{op: 3'd1, lo: 2'd2, data: 32'h80FF7F01, req: 32'hFFFFFFFF};
    vecs[3] = '{op: 3'd3, lo: 2'd2, data: 32'h8001F00F, req: 32'hFFFF8001};
    vecs[4] = '{op: 3'd4, lo: 2'd0, data: 32'h8001F00F, req: 32'h0000F00F};
    vecs[5] = '{op: 3'd5, lo: 2'd3, data: 32'h8001F00F, req: 32'h8001F00F};

    mv             = 1'b0;
    exp_retire     = '0;
    resetn         = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_pc          = '0;
    ms_gr_we       = 1'b0;
    ms_dest        = '0;
    ms_result      = '0;
    ms_ld_op       = '0;
    ms_ld_addr_lo  = '0;
    ms_ld_data     = '0;
    trace_stall    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_allowin", {31'b0, ws_allowin}, 32'h1);
    check("rst_rf_we", {31'b0, rf_we}, 32'h0);
    check("rst_retire", retire_cnt, 32'h0);
    check("rst_dbg_pc", debug_wb_pc, 32'h0);
    check("rst_dbg_we", {28'b0, debug_wb_rf_we}, 32'h0);
    check("rst_dbg_wnum", {27'b0, debug_wb_rf_wnum}, 32'h0);
    check("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);
    check("rst_fwd_valid", {31'b0, ws_fwd_valid}, 32'h0);
    resetn = 1'b1;

    // ALU write.
    issue_simple(32'h1c000000, 5'd5, 32'h12345678);
    idle(1'b0);
    check("alu_rf_we", {31'b0, rf_we}, 32'h1);
    check("alu_waddr", {27'b0, rf_waddr}, 32'd5);
    check("alu_wdata", rf_wdata, 32'h12345678);
    check("alu_dbg_we", {28'b0, debug_wb_rf_we}, 32'hF);
    idle(1'b0);
    check("alu_retire", retire_cnt, 32'd1);

    // Byte/half/word loads against hand-computed values.
    foreach (vecs[i]) begin
      issue(1'b1, 32'h1c000100 + 32'(i * 4), 1'b1, 5'd9, 32'hDEADBEEF, vecs[i].op, vecs[i].lo,
            vecs[i].data, 1'b0);
      idle(1'b0);
      check($sformatf("load_vec%0d", i), rf_wdata, vecs[i].req);
    end

    // Stall: held instruction, forwarding alive, new MEM data ignored.
    issue_simple(32'h1c000200, 5'd7, 32'hCAFE0007);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h1c0002f0, 1'b1, 5'd12, 32'h0BAD0BAD, 3'd0, 2'd0, 32'h0, 1'b1);
      check("stall_allowin", {31'b0, ws_allowin}, 32'h0);
      check("stall_rf_we", {31'b0, rf_we}, 32'h0);
      check("stall_fwd_valid", {31'b0, ws_fwd_valid}, 32'h1);
      check("stall_fwd_dest", {27'b0, ws_fwd_dest}, 32'd7);
      check("stall_fwd_data", ws_fwd_data, 32'hCAFE0007);
    end
    rc     = retire_cnt;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      if (rf_we === 1'b1) pulses++;
    end
    check("stall_release_pulses", 32'(pulses), 32'd1);
    check("stall_release_retire", retire_cnt, rc + 32'd1);

    // Back-to-back, dest 0 first.
    rc = retire_cnt;
    issue_simple(32'h1c000300, 5'd0, 32'h00000011);
    issue_simple(32'h1c000304, 5'd3, 32'h00000022);
    check("b2b_we0", {31'b0, rf_we}, 32'h1);
    check("b2b_fwd0", {31'b0, ws_fwd_valid}, 32'h0);
    issue_simple(32'h1c000308, 5'd3, 32'h00000033);
    check("b2b_we1", {31'b0, rf_we}, 32'h1);
    check("b2b_fwd1", {31'b0, ws_fwd_valid}, 32'h1);
    idle(1'b0);
    check("b2b_we2", {31'b0, rf_we}, 32'h1);
    check("b2b_data2", rf_wdata, 32'h00000033);
    idle(1'b0);
    check("b2b_idle", {31'b0, rf_we}, 32'h0);
    check("b2b_retire", retire_cnt, rc + 32'd3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      issue(1'($urandom_range(9) < 7), $urandom, 1'($urandom_range(7) != 0), 5'($urandom),
            $urandom, 3'($urandom_range(7)), 2'($urandom), $urandom,
            1'($urandom_range(3) == 0));
    end
    repeat (3) idle(1'b0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.retire_q = '1;
    #1;
    release dut.retire_q;
    exp_retire = '1;
    issue_simple(32'h1c000400, 5'd4, 32'h44444444);
    idle(1'b0);
    idle(1'b0);
    check("wrap_retire", retire_cnt, 32'h0);

    // Asynchronous reset while a write is leaving.
    issue_simple(32'h1c000500, 5'd6, 32'h66666666);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    trace_stall    = 1'b0;
    #1;
    check("midrst_pre_we", {31'b0, rf_we}, 32'h1);
    #3;
    resetn = 1'b0;
    #1;
    check("midrst_rf_we", {31'b0, rf_we}, 32'h0);
    check("midrst_allowin", {31'b0, ws_allowin}, 32'h1);
    check("midrst_retire", retire_cnt, 32'h0);
    check("midrst_fwd", {31'b0, ws_fwd_valid}, 32'h0);
    exp_q.delete();
    mv         = 1'b0;
    exp_retire = '0;
    @(negedge clk);
    resetn = 1'b1;
    idle(1'b0);
    check("post_rst_rf_we", {31'b0, rf_we}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage in-order pipeline. It sits directly upstream of the register file and drives its single write port. It accepts one instruction per cycle from the MEM stage through a valid/allowin handshake and holds it in a pipeline register. It then aligns and extends load data, drives the regfile write port, the ID-stage forwarding path, the debug trace and a retire counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  input  1  clock; all state on rising edge
resetn  input  1  asynchronous active-low reset
ms_to_ws_valid  input  1  MEM stage presents an instruction
ws_allowin  output  1  WB can accept this cycle
ms_pc  input  32  instruction PC
ms_gr_we  input  1  instruction writes a GR
ms_dest  input  5  destination GR number
ms_result  input  32  ALU/CSR result (non-load)
ms_ld_op  input  3  load type (package encoding)
ms_ld_addr_lo  input  2  load address bits [1:0]
ms_ld_data  input  32  raw data-SRAM read word
trace_stall  input  1  debug backpressure; holds WB when 1
rf_we  output  1  regfile write enable
rf_waddr  output  5  regfile write address
rf_wdata  output  32  regfile write data
ws_fwd_valid  output  1  WB holds a live GR write (for ID bypass/stall)
ws_fwd_dest  output  5  its destination
ws_fwd_data  output  32  its final write data
debug_wb_pc  output  32  trace PC
debug_wb_rf_we  output  4  trace byte enables ({4{rf_we}})
debug_wb_rf_wnum  output  5  trace GR number
debug_wb_rf_wdata  output  32  trace data
retire_cnt  output  RETIRE_W  count of instructions leaving WB

Behaviour:
- State: ws_valid plus registered copies of all ms_* fields. On reset, all of these are 0 and retire_cnt is 0. Every output is therefore 0 during and after reset, except ws_allowin = 1.
- ws_ready_go = ~trace_stall. ws_allowin = ~ws_valid | ws_ready_go.
- Capture: when ms_to_ws_valid & ws_allowin, the fields are latched and ws_valid <= 1 on the next edge.
- Leave without capture: when ws_valid & ws_ready_go & ~ms_to_ws_valid, ws_valid <= 0.
- When ws_allowin = 0, the registers hold and ms_* inputs are ignored.
- Latency: an instruction accepted at edge N drives rf_we in cycle N (the cycle after the edge), provided trace_stall = 0.
- rf_we = ws_valid & ws_gr_we & ws_ready_go. This asserts exactly once per instruction, in its leaving cycle, and never while stalled. Dest 0 is still written; the regfile masks r0.
- rf_waddr = ws_dest. rf_wdata = final data.
- Final data: if ld_op is NONE, ws_result. Otherwise the aligned load value:
  - B/BU: byte = ld_data[8*addr_lo +: 8], sign- or zero-extended.
  - H/HU: half = addr_lo[1] ? ld_data[31:16] : ld_data[15:0], sign- or zero-extended. addr_lo[0] is ignored; misalignment is trapped upstream.
  - W: ld_data unchanged.
  - Encodings 6 and 7 behave as NONE.
- Forwarding: ws_fwd_valid = ws_valid & ws_gr_we & (ws_dest != 0). It stays asserted while stalled, so ID keeps bypassing. ws_fwd_data equals the final data.
- Trace: debug_wb_pc = ws_pc. debug_wb_rf_we = {4{rf_we}}. debug_wb_rf_wnum = ws_dest. debug_wb_rf_wdata = rf_wdata.
- retire_cnt increments when ws_valid & ws_ready_go, and wraps to 0 after all-ones.
- Simultaneous leave and capture in one cycle: the new instruction replaces the old one with no bubble, and ws_valid stays 1.
- Reset mid-operation: ws_valid clears immediately (asynchronously) and rf_we drops in the same cycle. The in-flight write is lost.

Decomposition:
- Shared package (pipeline constants): LD_NONE=0, LD_B=1, LD_BU=2, LD_H=3, LD_HU=4, LD_W=5; ld_op width 3; GR address width 5.
- One combinational sub-module, load_align (ld_op, addr_lo, ld_data -> aligned 32-bit value). It is reused later by the MEM-stage forwarding path.
- wb_stage holds only the handshake, the pipeline registers, the counter and the output muxing.

Test Plan:
- Reset behaviour: resetn=0 for 3 cycles -> ws_allowin=1, rf_we=0, retire_cnt=0, all debug outputs 0. Pulse resetn low while ws_valid=1 -> rf_we drops at once.
- ALU write: pc=0x1c000000, gr_we=1, dest=5, result=0x12345678, ld_op=NONE -> next cycle rf_we=1, waddr=5, wdata=0x12345678, debug_wb_rf_we=4'hf, retire_cnt=1.
- Byte loads: ld_data=0x80FF7F01. LD_B with addr_lo=3 -> wdata=0xFFFFFF80. LD_BU with addr_lo=1 -> 0x0000007F. LD_B with addr_lo=2 -> 0xFFFFFFFF.
- Half and word loads: ld_data=0x8001F00F. LD_H with addr_lo=2 -> 0xFFFF8001. LD_HU with addr_lo=0 -> 0x0000F00F. LD_W with addr_lo=3 -> 0x8001F00F.
- Stall: hold trace_stall=1 for 4 cycles with ws_valid=1 and dest=7 ->
  - ws_allowin=0, rf_we=0 and the instruction is held.
  - ws_fwd_valid=1 with dest 7.
  - On release, exactly one rf_we pulse and retire_cnt increments by 1.
- Back-to-back and dest 0: 3 consecutive instructions, dests 0, 3, 3 ->
  - 3 rf_we pulses on consecutive cycles.
  - ws_fwd_valid=0 for dest 0.
  - retire_cnt=3.
  - Separately, preload retire_cnt to all-ones (forced via the bench) -> it wraps to 0.
